// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Autonomous serial reader for one NES controller (one instance per player).
//   A free-running poll timer starts a read sequence at the poll rate. Each
//   sequence drives the latch strobe, then 7 clock pulses. It shifts in the
//   8 active-low button bits and publishes them as active-high registers.
//   A one-cycle "newly pressed" vector accompanies each published result.
//
// Parameters
//   HALF_PERIOD  cycles per half-bit phase (>= 3)
//   POLL_COUNT   cycles between poll starts (> 17*HALF_PERIOD + 4)
//
// Ports
//   clk            system pixel clock
//   reset_n        synchronous active-low reset
//   nes_data       serial data from controller (active-low, asynchronous)
//   nes_latch      latch strobe to controller (active-high, registered)
//   nes_pulse      clock pulse to controller (active-high, registered)
//   buttons[7:0]   held buttons, 1 = held: A,B,Select,Start,Up,Down,Left,Right
//   pressed[7:0]   buttons that went 0->1 this poll, valid with buttons_valid
//   buttons_valid  one-cycle strobe when buttons/pressed update
//   busy           high while a read sequence is in progress
//
// Build option
//   NES_DEBOUNCE_EN  when defined, a poll result is published only if it
//                    matches the previous raw poll result. On a mismatch,
//                    buttons_valid still pulses, buttons is held, and
//                    pressed stays 0.

module nes_controller_reader #(
   parameter int HALF_PERIOD = 152,
   parameter int POLL_COUNT  = 419583
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_pulse,
   output logic [7:0] buttons,
   output logic [7:0] pressed,
   output logic       buttons_valid,
   output logic       busy
);

   localparam int TW = $clog2(POLL_COUNT);
   localparam int PW = $clog2(2 * HALF_PERIOD);
   localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_COUNT - 1);
   localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
   localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SETTLE,
      PULSE_HI,
      PULSE_LO,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_next;
   logic [TW-1:0] poll_cnt;
   logic [PW-1:0] phase_cnt;
   logic          start;
   logic          phase_end;
   logic          sample;
   logic [2:0]    sample_idx;
   logic [7:0]    shift;
   logic [7:0]    raw;
   logic          data_p0;
   logic          data_p1;

   // Stage boundary: two-flop synchronizer for the asynchronous controller data
   always_ff @(posedge clk) begin
      data_p0 <= nes_data;
      data_p1 <= data_p0;
   end

   // Poll timer: wraps at POLL_COUNT-1 and strobes start on that cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         poll_cnt <= '0;
      end else if (poll_cnt == POLL_LAST) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + 1'b1;
      end
   end

   assign start = (poll_cnt == POLL_LAST);

   // The latch phase is two half-periods long; all other timed phases are one
   assign phase_end = (state == LATCH) ? (phase_cnt == LATCH_LAST)
                                       : (phase_cnt == HALF_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_cnt <= '0;
      end else if (state == IDLE || state == DONE || phase_end) begin
         phase_cnt <= '0;
      end else begin
         phase_cnt <= phase_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      bit_idx_next = bit_idx;
      case (state)
         IDLE: begin
            if (start) state_next = LATCH;
         end
         LATCH: begin
            if (phase_end) state_next = SETTLE;
         end
         SETTLE: begin
            if (phase_end) begin
               state_next   = PULSE_HI;
               bit_idx_next = 3'd1;
            end
         end
         PULSE_HI: begin
            if (phase_end) state_next = PULSE_LO;
         end
         PULSE_LO: begin
            if (phase_end) begin
               if (bit_idx == 3'd7) begin
                  state_next = DONE;
               end else begin
                  state_next   = PULSE_HI;
                  bit_idx_next = bit_idx + 3'd1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Stage boundary: state register, with latch/pulse registered from next state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_idx   <= 3'd0;
         nes_latch <= 1'b0;
         nes_pulse <= 1'b0;
      end else begin
         state     <= state_next;
         bit_idx   <= bit_idx_next;
         nes_latch <= (state_next == LATCH);
         nes_pulse <= (state_next == PULSE_HI);
      end
   end

   assign busy = (state != IDLE);

   // Bit 0 (A) is valid after the latch falls; later bits follow each pulse
   assign sample     = phase_end && (state == SETTLE || state == PULSE_LO);
   assign sample_idx = (state == SETTLE) ? 3'd0 : bit_idx;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift <= 8'h00;
      end else if (sample) begin
         shift[sample_idx] <= data_p1;
      end
   end

   assign raw = ~shift;

`ifdef NES_DEBOUNCE_EN
   logic [7:0] raw_prev;
`endif

   // Stage boundary: publish registers, updated from the DONE state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buttons       <= 8'h00;
         pressed       <= 8'h00;
         buttons_valid <= 1'b0;
`ifdef NES_DEBOUNCE_EN
         raw_prev      <= 8'h00;
`endif
      end else begin
         buttons_valid <= (state == DONE);
         pressed       <= 8'h00;
         if (state == DONE) begin
`ifdef NES_DEBOUNCE_EN
            raw_prev <= raw;
            if (raw == raw_prev) begin
               buttons <= raw;
               pressed <= raw & ~buttons;
            end
`else
            buttons <= raw;
            pressed <= raw & ~buttons;
`endif
         end
      end
   end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
- Autonomous serial reader for one NES controller; one instance per player, left and right.
- Generates the controller latch/pulse waveform at the poll rate, shifts in the 8 button bits and presents them as active-high registers.
- Also emits a one-cycle "newly pressed" vector per poll. The Pong datapath consumes `pressed` directly in place of its own edge detection.
- Sits between the NES connector pins and the paddle/game-control logic.

Parameters:
- HALF_PERIOD, 152, cycles per half-bit phase (~6 us at 25.175 MHz); must be >= 3.
- POLL_COUNT, 419583, cycles between poll starts (~60 Hz); must be > 17*HALF_PERIOD + 4.

Ports:
- clk  input  1  system pixel clock
- reset_n  input  1  synchronous active-low reset
- nes_data  input  1  serial data from controller, active-low, asynchronous
- nes_latch  output  1  latch strobe to controller, active-high
- nes_pulse  output  1  clock pulse to controller, active-high
- buttons  output  8  current button state, 1 = held; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- pressed  output  8  buttons that went 0->1 this poll; nonzero only while buttons_valid = 1
- buttons_valid  output  1  one-cycle strobe when buttons/pressed update
- busy  output  1  high while a read sequence is in progress

Behaviour:
- Reset is synchronous and active-low, sampled on posedge clk only. While reset_n = 0: nes_latch = 0, nes_pulse = 0, buttons = 0, pressed = 0, buttons_valid = 0, busy = 0, poll timer = 0, FSM = IDLE, shift register = 0.
- Asserting reset mid-sequence aborts it. Latch and pulse are low on the first edge with reset_n = 0, and no partial result is published.
- nes_data passes through a 2-flop synchronizer before sampling.
- Poll timer:
  - Free-running, counts 0..POLL_COUNT-1 and wraps.
  - Issues a start strobe on the cycle it equals POLL_COUNT-1, so the first start occurs POLL_COUNT cycles after reset release.
  - A start strobe seen when FSM is not IDLE is ignored; this is unreachable under the parameter rule.
- Phase counter: counts 0..HALF_PERIOD-1 inside each FSM phase. A phase "ends" when the counter reaches HALF_PERIOD-1.
- FSM states and transitions:
  - IDLE: latch = 0, pulse = 0, busy = 0. On start strobe -> LATCH.
  - LATCH: latch = 1 for 2*HALF_PERIOD cycles -> SETTLE.
  - SETTLE: latch = 0 for HALF_PERIOD cycles. At the end, sample the synchronized data into bit 0, with bit_idx = 1 -> PULSE_HI.
  - PULSE_HI: pulse = 1 for HALF_PERIOD cycles -> PULSE_LO.
  - PULSE_LO: pulse = 0 for HALF_PERIOD cycles. At the end, sample into bit[bit_idx]. If bit_idx = 7 -> DONE; else bit_idx+1 -> PULSE_HI.
  - DONE: one cycle. Then buttons <= ~shift, pressed <= ~shift & ~buttons_old, buttons_valid = 1 -> IDLE.
- In the cycle after DONE, buttons_valid = 0 and pressed = 0; buttons holds its value.
- busy = 1 in every state except IDLE.
- Exactly 7 pulses per sequence.
- nes_latch and nes_pulse are registered outputs and are never high simultaneously.
- Sequence length: latch rises 1 cycle after the start strobe. buttons_valid fires 17*HALF_PERIOD + 1 cycles after latch rises.
- Controller unplugged (data pulled high) reads all 1 -> buttons = 0x00, which is not an error.

Optional Feature:
- Macro: NES_DEBOUNCE_EN.
- Defined: a poll result is published only if it equals the previous raw poll result, held in an extra 8-bit register.
  - On mismatch: the raw register updates, buttons/pressed stay unchanged, and buttons_valid still pulses with pressed = 0.
- Undefined: every poll result is published immediately.

Test Plan:
- Parameters HALF_PERIOD=4, POLL_COUNT=200, nes_data tied 1:
  - first latch rise at cycle 201 after reset release;
  - latch high exactly 8 cycles;
  - exactly 7 pulses, each 4 high / 4 low;
  - buttons_valid one cycle, 69 cycles after latch rise;
  - buttons = 0x00.
- Model controller drives A low before the first pulse and Up low after pulse 4 -> buttons = 0x11 and pressed = 0x11 on the first poll. The next identical poll gives buttons = 0x11, pressed = 0x00.
- Release A, keep Up held -> buttons = 0x10, pressed = 0x00. Press Start -> pressed = 0x08.
- reset_n low for 1 cycle during PULSE_HI of bit 3 -> next edge has latch = 0, pulse = 0, busy = 0, buttons = 0x00. No buttons_valid until the next full poll, 200 cycles later.
- NES_DEBOUNCE_EN defined, alternate raw polls 0x01/0x00/0x00 -> buttons stays 0x00 after polls 1 and 2 and updates to 0x00 on poll 3. Then two consecutive polls of 0x01 -> buttons = 0x01 and pressed = 0x01 on the second poll.
- Assertions over the whole run:
  - latch and pulse are never both 1;
  - pressed is nonzero only while buttons_valid = 1;
  - buttons is stable whenever buttons_valid = 0.
